// File: rtl/sumdiff_decoder.sv
// Two-stage decoder for (sum, difference) pairs: recovers a = (s+d)/2, b = (s-d)/2,
// flags pairs that no W-bit operands could have produced, and counts deliveries.
module sumdiff_decoder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_sum,
  input  logic [W:0]   in_diff,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_err,
  output logic [15:0]  pair_count,
  output logic [15:0]  err_count
);

  localparam int TW = W + 3;
  localparam logic signed [TW-1:0] T_MAX = TW'(2 * ((1 << W) - 1));

  logic                 s1_valid;
  logic                 s2_valid;
  logic signed [TW-1:0] t_a;
  logic signed [TW-1:0] t_b;
  logic signed [TW-1:0] ext_sum;
  logic signed [TW-1:0] ext_diff;
  logic                 s2_free;
  logic                 s1_move;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 s2_err;

  // NOTE: in_ready is built only from occupancy and out_ready, never from in_valid,
  // so upstream may legally wait for ready before raising valid without a comb loop.
  assign s2_free   = !s2_valid || out_ready;
  assign s1_move   = s1_valid && s2_free;
  assign in_ready  = rst_n && (!s1_valid || s2_free);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  assign ext_sum  = signed'({2'b00, in_sum});
  assign ext_diff = signed'({{2{in_diff[W]}}, in_diff});

  // t_a and t_b share parity, so checking t_a[0] covers both.
  assign s2_err = t_a[0] || t_a[TW-1] || (t_a > T_MAX) || t_b[TW-1] || (t_b > T_MAX);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      t_a      <= '0;
      t_b      <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      t_a      <= ext_sum + ext_diff;
      t_b      <= ext_sum - ext_diff;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_a    <= '0;
      out_b    <= '0;
      out_err  <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      out_a    <= s2_err ? '0 : t_a[W:1];
      out_b    <= s2_err ? '0 : t_b[W:1];
      out_err  <= s2_err;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
      err_count  <= '0;
    end else if (clr) begin
      pair_count <= '0;
      err_count  <= '0;
    end else if (out_xfer) begin
      if (pair_count != 16'hFFFF) pair_count <= pair_count + 16'd1;
      if (out_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: doc/sumdiff_decoder.md
Name: sumdiff_decoder

Overview:
- Receives (sum, difference) pairs, where sum = a+b and difference = a-b.
- Recovers the original unsigned operands as a = (sum+diff)/2 and b = (sum-diff)/2.
- It is the decode end of the sum/difference packing used by the arithmetic task blocks.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Flags inconsistent pairs and keeps pair and error statistics.

Parameters:
- W, 8, operand width in bits. Recovered a and b are W bits; in_sum is W+1 bits; in_diff is W+1 bits two's complement.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of pair_count and err_count
- in_valid  input  1  input pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_sum  input  W+1  unsigned a+b
- in_diff  input  W+1  signed a-b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_a  output  W  recovered a
- out_b  output  W  recovered b
- out_err  output  1  pair was inconsistent; out_a and out_b are forced to 0
- pair_count  output  16  saturating count of results delivered
- err_count  output  16  saturating count of results delivered with out_err=1

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: all outputs, pipeline valids and counters are 0, except in_ready, which is 1 once rst_n is high.
- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - Each stage holds an occupancy bit.
  - A stage may load when it is empty or when its contents move forward the same cycle.
  - in_ready = !s1_valid || (s1 moves to s2 this cycle).
  - s1 moves when !s2_valid || out_ready.
  - in_ready must not depend combinationally on in_valid.
- Stage 1:
  - Sign-extend both operands to W+3 bits signed (in_sum zero-extended, in_diff sign-extended).
  - Register t_a = sum+diff and t_b = sum-diff.
- Stage 2:
  - err = t_a[0] (parity mismatch) OR t_a<0 OR t_a>2*(2^W-1) OR t_b<0 OR t_b>2*(2^W-1).
  - t_a and t_b always have equal parity, so one parity check suffices.
  - If err=0: out_a = t_a>>>1 and out_b = t_b>>>1, truncated to W bits.
  - If err=1: out_a = out_b = 0 and out_err = 1.
- Latency: accept to out_valid is exactly 2 cycles with out_ready held high.
- Throughput: 1 pair per cycle.
- Stall behaviour:
  - out_valid stays high and out_a, out_b, out_err stay stable until accepted.
  - With out_ready low, the pipeline fills: at most 2 pairs are accepted, then in_ready drops.
  - Order is preserved; no pair is lost or duplicated.
- Counters:
  - pair_count increments on each output transfer.
  - err_count increments on each output transfer with out_err=1.
  - Both saturate at 16'hFFFF.
  - clr has priority over increment in the same cycle.
  - clr does not affect the pipeline.
- Asynchronous reset mid-operation: pipeline contents are discarded, out_valid drops immediately and counters clear.
- Illegal sum = 2^(W+1)-1 (cannot arise from W-bit operands) is caught by the range check and flagged as err.

Test Plan:
- Single pair, out_ready=1: in_sum=27, in_diff=3 -> 2 cycles later out_a=15, out_b=12, out_err=0; pair_count=1.
- Boundary pairs:
  - sum=510, diff=0 -> a=255, b=255.
  - sum=255, diff=255 -> a=255, b=0.
  - sum=255, diff=-255 -> a=0, b=255.
  - All with out_err=0.
- Error pairs:
  - sum=27, diff=4 -> out_err=1 (parity), a=b=0.
  - sum=10, diff=-20 -> out_err=1 (range).
  - sum=511, diff=1 -> out_err=1 (range).
  - err_count=3 after the three transfers.
- Backpressure: stream the pairs (27,3), (20,2), (8,-2) with out_ready=0 for 6 cycles.
  - in_ready drops after 2 accepts and out_a/out_b hold at 15/12.
  - On release, the outputs are (15,12), (11,9), (3,5) in that order; no gaps at out_ready=1.
- Full throughput: 20 back-to-back valid pairs with out_ready=1 -> in_ready stays 1 and 20 results arrive on consecutive cycles.
- Reset and counters:
  - Assert rst_n=0 with 2 pairs in flight -> out_valid=0 asynchronously, and no stale output after release.
  - Force pair_count near 16'hFFFF (via many transfers or a hierarchical deposit) -> it sticks at FFFF.
  - clr with a simultaneous transfer -> counters read 0 the next cycle.
